// File: rtl/fdiv_half_precision_seq_pkg.sv
// Shared half-precision field widths and constants, plus the divider FSM state type.
package fdiv_half_precision_seq_pkg;

    localparam int HP_EXP_W   = 5;
    localparam int HP_MAN_W   = 10;
    localparam int HP_BIAS    = 15;
    localparam int HP_EXP_MAX = 31;
    localparam int HP_SIG_W   = HP_MAN_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2
    } fdiv_state_t;

endpackage

// File: rtl/fdiv_half_precision_seq_restoring_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, emit quotient bit.
module restoring_div_step
    import fdiv_half_precision_seq_pkg::*;
(
    input  logic [HP_SIG_W-1:0] rem,
    input  logic                bit_in,
    input  logic [HP_SIG_W-1:0] divisor,
    output logic [HP_SIG_W-1:0] rem_next,
    output logic                q_bit
);

    logic [HP_SIG_W:0]   shifted;
    logic [HP_SIG_W-1:0] diff;

    // rem < divisor holds on entry, so the true difference fits in HP_SIG_W bits.
    always_comb begin
        shifted  = {rem, bit_in};
        q_bit    = (shifted >= {1'b0, divisor});
        diff     = shifted[HP_SIG_W-1:0] - divisor;
        rem_next = q_bit ? diff : shifted[HP_SIG_W-1:0];
    end

endmodule

// File: rtl/fdiv_half_precision_seq.sv
// Sequential half-precision divider: 12-cycle restoring mantissa divide, then one
// normalise/flag cycle. Truncating, subnormals flushed, fixed 13-cycle latency.
module fdiv_half_precision_seq
    import fdiv_half_precision_seq_pkg::*;
#(
    parameter int BIAS   = HP_BIAS,
    parameter int Q_BITS = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_Start,
    input  logic                in_Sign_1,
    input  logic [HP_EXP_W-1:0] in_Exponent_1,
    input  logic [HP_MAN_W-1:0] in_Mantissa_1,
    input  logic                in_Sign_2,
    input  logic [HP_EXP_W-1:0] in_Exponent_2,
    input  logic [HP_MAN_W-1:0] in_Mantissa_2,
    output logic                out_Sign,
    output logic [HP_EXP_W-1:0] out_Exponent,
    output logic [HP_MAN_W-1:0] out_Mantissa,
    output logic                out_Busy,
    output logic                out_Done,
    output logic                Exponent_Overflow,
    output logic                Exponent_Underflow,
    output logic                Divide_By_Zero
);

    localparam int CNT_W = $clog2(Q_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(Q_BITS - 1);
    localparam logic signed [7:0] BIAS_S    = 8'(BIAS);
    localparam logic signed [7:0] EXP_MAX_S = 8'(HP_EXP_MAX);

    fdiv_state_t         state;
    logic [CNT_W-1:0]    count;
    logic                sign_r;
    logic [HP_EXP_W-1:0] exp_a;
    logic [HP_EXP_W-1:0] exp_b;
    logic [HP_SIG_W-1:0] sig_b;
    logic [HP_SIG_W-1:0] rem;
    logic [Q_BITS-1:0]   dvd_bits;
    logic [Q_BITS-1:0]   quot;

    logic [HP_SIG_W-1:0] rem_next;
    logic                q_bit;
    logic                norm_adj;
    logic [HP_MAN_W-1:0] norm_man;
    logic signed [7:0]   exp_calc;

    restoring_div_step u_step (
        .rem      (rem),
        .bit_in   (dvd_bits[Q_BITS-1]),
        .divisor  (sig_b),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        norm_adj = ~quot[Q_BITS-1];
        norm_man = quot[Q_BITS-1] ? quot[Q_BITS-2:1] : quot[Q_BITS-3:0];
        exp_calc = $signed({3'b000, exp_a}) - $signed({3'b000, exp_b}) + BIAS_S
                   - $signed({7'd0, norm_adj});
    end

    // The top ten dividend bits of A<<11 always leave a remainder of A>>1 (< B),
    // so the divide starts there and only the last twelve bits are iterated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            count              <= '0;
            sign_r             <= 1'b0;
            exp_a              <= '0;
            exp_b              <= '0;
            sig_b              <= '0;
            rem                <= '0;
            dvd_bits           <= '0;
            quot               <= '0;
            out_Sign           <= 1'b0;
            out_Exponent       <= '0;
            out_Mantissa       <= '0;
            out_Busy           <= 1'b0;
            out_Done           <= 1'b0;
            Exponent_Overflow  <= 1'b0;
            Exponent_Underflow <= 1'b0;
            Divide_By_Zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_Done <= 1'b0;
                    if (in_Start) begin
                        sign_r   <= in_Sign_1 ^ in_Sign_2;
                        exp_a    <= in_Exponent_1;
                        exp_b    <= in_Exponent_2;
                        sig_b    <= {1'b1, in_Mantissa_2};
                        rem      <= {2'b01, in_Mantissa_1[HP_MAN_W-1:1]};
                        dvd_bits <= {in_Mantissa_1[0], {(Q_BITS-1){1'b0}}};
                        quot     <= '0;
                        count    <= '0;
                        out_Busy <= 1'b1;
                        state    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem      <= rem_next;
                    dvd_bits <= dvd_bits << 1;
                    quot     <= {quot[Q_BITS-2:0], q_bit};
                    count    <= count + 1'b1;
                    if (count == CNT_LAST) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    out_Sign           <= sign_r;
                    out_Done           <= 1'b1;
                    out_Busy           <= 1'b0;
                    state              <= IDLE;
                    Exponent_Overflow  <= 1'b0;
                    Exponent_Underflow <= 1'b0;
                    Divide_By_Zero     <= 1'b0;
                    if (exp_b == '0) begin
                        Divide_By_Zero <= 1'b1;
                        out_Exponent   <= '1;
                        out_Mantissa   <= '0;
                    end else if (exp_a == '0) begin
                        out_Exponent <= '0;
                        out_Mantissa <= '0;
                    end else if (exp_calc >= EXP_MAX_S) begin
                        Exponent_Overflow <= 1'b1;
                        out_Exponent      <= '1;
                        out_Mantissa      <= '0;
                    end else if (exp_calc <= 8'sd0) begin
                        Exponent_Underflow <= 1'b1;
                        out_Exponent       <= '0;
                        out_Mantissa       <= '0;
                    end else begin
                        out_Exponent <= exp_calc[HP_EXP_W-1:0];
                        out_Mantissa <= norm_man;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
